inv_cipher_iter: RTL and testbench

Iterative AES inverse cipher (FIPS-197 InvCipher) for AES-128/192/256, selected by the same `(Nk, Nr)` parameter pair the forward `Cipher` uses. It accepts one ciphertext block and one cipher key over a valid/ready handshake and expands the key schedule internally, one word per cycle. It then executes one inverse round per cycle and presents the plaintext on a valid/ready output. It is the decryption counterpart of `Cipher` and sits beside it in the AES system datapath.

---
 rtl/inv_cipher_iter_if.sv | 24 ++
 rtl/inv_cipher_iter.sv | 207 ++++++++++++++++++++
 tb/tb_inv_cipher_iter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/inv_cipher_iter_if.sv
// Input/output bundle of the iterative AES inverse cipher.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// source holds valid and its payload until then, and ready never waits on valid.
interface inv_cipher_iter_if #(
  parameter int NK = 4
) ();
  logic              in_valid;
  logic              in_ready;
  logic [127:0]      in_data;
  logic [32*NK-1:0]  in_key;
  logic              out_valid;
  logic              out_ready;
  logic [127:0]      out_data;

  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/inv_cipher_iter.sv
// Iterative AES-128/192/256 inverse cipher: expands the key schedule one word
// per cycle, then runs one inverse round per cycle and holds the plaintext.
module inv_cipher_iter #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  inv_cipher_iter_if.slave bus,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  localparam int NW = 4 * (Nr + 1);
  localparam int IW = $clog2(NW);
  localparam logic [IW-1:0] NK_W   = IW'(Nk);
  localparam logic [IW-1:0] LAST_I = IW'(NW - 1);
  localparam logic [2:0]    K_LAST = 3'(Nk - 1);
  localparam logic [3:0]    NR_W   = 4'(Nr);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_ROUND  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e        state_q;
  logic [IW-1:0] i_q;
  logic [2:0]    k_q;
  logic [7:0]    rcon_q;
  logic [3:0]    r_q;
  logic [31:0]   w_q [NW];
  logic [127:0]  st_q;
  logic [127:0]  out_q;

  logic [31:0]   exp_temp_d;
  logic [31:0]   exp_word_d;
  logic [IW-1:0] kidx_d;
  logic [127:0]  rk_d;
  logic [127:0]  inv_d;
  logic [127:0]  st_d;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int k = 0; k < 7; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte n of the state lives at [127-8n -: 8]; row r, column c is byte r+4c.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) begin
      o[127 - 8*n -: 8] = inv_sbox(s[127 - 8*n -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c      -: 8];
      a1 = s[127 - 32*c - 8  -: 8];
      a2 = s[127 - 32*c - 16 -: 8];
      a3 = s[127 - 32*c - 24 -: 8];
      o[127 - 32*c      -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[127 - 32*c - 8  -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[127 - 32*c - 16 -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[127 - 32*c - 24 -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // k_q tracks i mod Nk and rcon_q tracks Rcon[i/Nk], so no divider is needed.
  always_comb begin
    exp_temp_d = w_q[i_q - IW'(1)];
    if (k_q == 3'd0) begin
      exp_temp_d = sub_word({exp_temp_d[23:0], exp_temp_d[31:24]}) ^ {rcon_q, 24'h000000};
    end else if (Nk == 8 && k_q == 3'd4) begin
      exp_temp_d = sub_word(exp_temp_d);
    end
    exp_word_d = w_q[i_q - NK_W] ^ exp_temp_d;
  end

  always_comb begin
    kidx_d = IW'({r_q, 2'b00});
    rk_d   = {w_q[kidx_d], w_q[kidx_d + IW'(1)], w_q[kidx_d + IW'(2)], w_q[kidx_d + IW'(3)]};
    inv_d  = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_d;
    if (r_q == NR_W) begin
      st_d = st_q ^ rk_d;
    end else if (r_q == 4'd0) begin
      st_d = inv_d;
    end else begin
      st_d = inv_mix_columns(inv_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      k_q     <= '0;
      rcon_q  <= '0;
      r_q     <= '0;
      st_q    <= '0;
      out_q   <= '0;
      for (int j = 0; j < NW; j++) w_q[j] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            st_q <= bus.in_data;
            for (int j = 0; j < Nk; j++) w_q[j] <= bus.in_key[32*(Nk-1-j) +: 32];
            i_q     <= NK_W;
            k_q     <= '0;
            rcon_q  <= 8'h01;
            state_q <= S_EXPAND;
          end
        end
        S_EXPAND: begin
          w_q[i_q] <= exp_word_d;
          i_q      <= i_q + IW'(1);
          k_q      <= (k_q == K_LAST) ? 3'd0 : k_q + 3'd1;
          if (k_q == 3'd0) rcon_q <= xtime(rcon_q);
          if (i_q == LAST_I) begin
            r_q     <= NR_W;
            state_q <= S_ROUND;
          end
        end
        S_ROUND: begin
          st_q <= st_d;
          if (r_q == 4'd0) begin
            out_q   <= st_d;
            state_q <= S_DONE;
          end else begin
            r_q <= r_q - 4'd1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_data  = out_q;
  assign busy          = (state_q != S_IDLE);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_inv_cipher_iter.sv
// Bench for inv_cipher_iter: one instance per key size, FIPS-197 vectors,
// backpressure, ignored inputs while busy, and asynchronous reset mid-round.
module tb_inv_cipher_iter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]   in_valid  = '0;
  logic [2:0]   out_ready = '0;
  logic [127:0] in_data   = '0;
  logic [255:0] key_l     = '0;

  inv_cipher_iter_if #(.NK(4)) if0 ();
  inv_cipher_iter_if #(.NK(6)) if1 ();
  inv_cipher_iter_if #(.NK(8)) if2 ();

  assign if0.in_valid  = in_valid[0];
  assign if1.in_valid  = in_valid[1];
  assign if2.in_valid  = in_valid[2];
  assign if0.out_ready = out_ready[0];
  assign if1.out_ready = out_ready[1];
  assign if2.out_ready = out_ready[2];
  assign if0.in_data   = in_data;
  assign if1.in_data   = in_data;
  assign if2.in_data   = in_data;
  assign if0.in_key    = key_l[255 -: 128];
  assign if1.in_key    = key_l[255 -: 192];
  assign if2.in_key    = key_l;

  logic       busy0, busy1, busy2;
  logic [1:0] dbg0, dbg1, dbg2;

  inv_cipher_iter #(.Nk(4), .Nr(10)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave), .busy(busy0), .dbg_state_o(dbg0));
  inv_cipher_iter #(.Nk(6), .Nr(12)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave), .busy(busy1), .dbg_state_o(dbg1));
  inv_cipher_iter #(.Nk(8), .Nr(14)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave), .busy(busy2), .dbg_state_o(dbg2));

  wire [2:0] in_ready_w  = {if2.in_ready,  if1.in_ready,  if0.in_ready};
  wire [2:0] out_valid_w = {if2.out_valid, if1.out_valid, if0.out_valid};
  wire [2:0] busy_w      = {busy2, busy1, busy0};
  logic [127:0] out_data_w [3];
  logic [1:0]   dbg_w      [3];
  assign out_data_w[0] = if0.out_data;
  assign out_data_w[1] = if1.out_data;
  assign out_data_w[2] = if2.out_data;
  assign dbg_w[0] = dbg0;
  assign dbg_w[1] = dbg1;
  assign dbg_w[2] = dbg2;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    int           sel;
    logic [255:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    int           lat;
    int           bp;
    bit           garbage;
  } vec_t;

  vec_t vecs [5];

  // ---------------- driver ----------------
  task automatic do_vec(input vec_t v);
    int cnt;
    bit seen;
    in_data           = v.ct;
    key_l             = v.key;
    in_valid[v.sel]   = 1'b1;
    out_ready[v.sel]  = 1'b0;
    check("in_ready_before_accept", 128'(in_ready_w[v.sel]), 128'd1);
    @(posedge clk); #1;
    in_valid[v.sel] = 1'b0;
    check("busy_after_accept", 128'(busy_w[v.sel]), 128'd1);
    check("state_expand", 128'(dbg_w[v.sel]), 128'd1);
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < 200) begin
      if (v.garbage) begin
        in_valid[v.sel] = 1'($urandom_range(0, 1));
        in_data         = {4{$urandom()}};
        key_l           = {8{$urandom()}};
      end
      @(posedge clk); #1;
      cnt++;
      seen = out_valid_w[v.sel];
    end
    in_valid[v.sel] = 1'b0;
    check("out_valid_seen", 128'(seen), 128'd1);
    check("latency", 128'(cnt), 128'(v.lat));
    check("plaintext", out_data_w[v.sel], v.pt);
    for (int b = 0; b < v.bp; b++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 128'(out_valid_w[v.sel]), 128'd1);
      check("bp_out_data", out_data_w[v.sel], v.pt);
    end
    out_ready[v.sel] = 1'b1;
    @(posedge clk); #1;
    out_ready[v.sel] = 1'b0;
    check("post_hs_out_valid", 128'(out_valid_w[v.sel]), 128'd0);
    check("post_hs_in_ready", 128'(in_ready_w[v.sel]), 128'd1);
    check("post_hs_busy", 128'(busy_w[v.sel]), 128'd0);
    check("post_hs_data_kept", out_data_w[v.sel], v.pt);
  endtask

  task automatic check_reset_vals(input string tag);
    for (int k = 0; k < 3; k++) begin
      check({tag, "_in_ready"},  128'(in_ready_w[k]),  128'd1);
      check({tag, "_out_valid"}, 128'(out_valid_w[k]), 128'd0);
      check({tag, "_busy"},      128'(busy_w[k]),      128'd0);
      check({tag, "_out_data"},  out_data_w[k],        128'd0);
      check({tag, "_state"},     128'(dbg_w[k]),       128'd0);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    bit pulse;
    vecs[0] = '{0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734, 51, 0, 1'b0};
    vecs[1] = '{1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                128'hdda97ca4864cdfe06eaf70a0ec0d7191, 128'h00112233445566778899aabbccddeeff, 59, 3, 1'b0};
    vecs[2] = '{2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h8ea2b7ca516745bfeafc49904b496089, 128'h00112233445566778899aabbccddeeff, 67, 0, 1'b0};
    vecs[3] = '{0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734, 51, 10, 1'b1};
    vecs[4] = '{0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 51, 0, 1'b0};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("after_reset");

    for (int n = 0; n < 5; n++) do_vec(vecs[n]);

    // Abort in the middle of the round phase with an off-edge reset.
    in_data     = vecs[0].ct;
    key_l       = vecs[0].key;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (45) @(posedge clk);
    check("pre_abort_state_round", 128'(dbg_w[0]), 128'd2);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("abort");
    pulse = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid_w[0]) pulse = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid_w[0]) pulse = 1'b1;
    end
    check("no_out_valid_after_abort", 128'(pulse), 128'd0);
    check("abort_out_data_cleared", out_data_w[0], 128'd0);
    do_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
